path_search_ctrl: RTL and testbench

Parametrised successor to the single-bit frequency/amplitude path finder in the rocking controller. Samples a multi-bit stress level and a flow flag on each enabled tick. Walks a registered frequency setpoint up or down, and backs off amplitude, to find a low-stress operating point. Sits between the sensor front-end and the motor drive, with a sticky fault path when stress persists.

---
 rtl/path_pkg.sv | 27 ++
 rtl/path_search_ctrl_stress_filter.sv | 39 +++
 rtl/path_search_ctrl.sv | 147 ++++++++++++++
 tb/tb_path_search_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/path_pkg.sv
// Shared types and helpers for the frequency/amplitude path search controller.
// The saturating helpers work on 32-bit carriers; callers pass the real width.
package path_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_CLIMB   = 3'd1,
        S_DESCEND = 3'd2,
        S_HOLD    = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/path_search_ctrl_stress_filter.sv
// Stress comparator; with STRESS_FILTER_EN defined, a 2-of-3 majority over the last three ticks.
// Combinational from stress_lvl to s; history shifts only on tick.
module stress_filter #(
    parameter int STRESS_W   = 4,
    parameter int STRESS_THR = 8
) (
    input  logic [STRESS_W-1:0] stress_lvl,
    output logic                s
`ifdef STRESS_FILTER_EN
    ,
    input  logic                clk,
    input  logic                reset,
    input  logic                tick
`endif
);

    logic raw;
    assign raw = (32'(stress_lvl) >= 32'(STRESS_THR));

`ifdef STRESS_FILTER_EN
    logic h1;
    logic h2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            h1 <= 1'b0;
            h2 <= 1'b0;
        end else if (tick) begin
            h1 <= raw;
            h2 <= h1;
        end
    end

    assign s = (raw & h1) | (raw & h2) | (h1 & h2);
`else
    assign s = raw;
`endif

endmodule

// File: rtl/path_search_ctrl.sv
// Walks freq/amp setpoints toward low stress, with sticky fault on persistent stress (STRESS_FILTER_EN adds majority filtering).
// Outputs registered, updated on the edge that samples tick=1; no backpressure.
module path_search_ctrl
    import path_pkg::*;
#(
    parameter int FREQ_W     = 8,
    parameter int AMP_W      = 8,
    parameter int STRESS_W   = 4,
    parameter int STRESS_THR = 8,
    parameter int STEP       = 4,
    parameter int FREQ_INIT  = 128,
    parameter int AMP_INIT   = 200,
    parameter int HOLD_CYC   = 4,
    parameter int ERR_LIMIT  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic [STRESS_W-1:0] stress_lvl,
    input  logic                flow,
    input  logic                clear_err,
    output logic [FREQ_W-1:0]   freq,
    output logic [AMP_W-1:0]    amp,
    output logic                fplus,
    output logic                fmin,
    output logic                amin,
    output logic                error,
    output logic [STATE_W-1:0]  state
);

    localparam int BAD_W  = $clog2(ERR_LIMIT + 1);
    localparam int HOLD_W = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);

    state_t            st;
    logic [BAD_W-1:0]  bad_cnt;
    logic [BAD_W-1:0]  bad_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              s;
    logic [FREQ_W-1:0] freq_up;
    logic [FREQ_W-1:0] freq_dn;
    logic [AMP_W-1:0]  amp_dn;

    stress_filter #(
        .STRESS_W  (STRESS_W),
        .STRESS_THR(STRESS_THR)
    ) u_filter (
        .stress_lvl(stress_lvl),
        .s         (s)
`ifdef STRESS_FILTER_EN
        ,
        .clk       (clk),
        .reset     (reset),
        .tick      (tick)
`endif
    );

    assign freq_up = FREQ_W'(sat_add(32'(freq), 32'(STEP), FREQ_W));
    assign freq_dn = FREQ_W'(sat_sub(32'(freq), 32'(STEP)));
    assign amp_dn  = AMP_W'(sat_sub(32'(amp), 32'(STEP)));
    assign state   = st;

    always_comb begin
        bad_nxt = '0;
        if (s) begin
            bad_nxt = (bad_cnt == BAD_W'(ERR_LIMIT)) ? bad_cnt : bad_cnt + BAD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st       <= S_IDLE;
            freq     <= FREQ_W'(FREQ_INIT);
            amp      <= AMP_W'(AMP_INIT);
            fplus    <= 1'b0;
            fmin     <= 1'b0;
            amin     <= 1'b0;
            error    <= 1'b0;
            bad_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            fplus <= 1'b0;
            fmin  <= 1'b0;
            amin  <= 1'b0;
            if (tick) begin
                bad_cnt <= bad_nxt;
                // Persistent stress preempts both the normal move and any clear request.
                if (st != S_FAULT && bad_nxt == BAD_W'(ERR_LIMIT)) begin
                    st    <= S_FAULT;
                    error <= 1'b1;
                end else begin
                    case (st)
                        S_IDLE: st <= S_CLIMB;
                        S_CLIMB: begin
                            if (s) begin
                                if (flow) begin
                                    freq  <= freq_up;
                                    fplus <= (freq_up != freq);
                                end else begin
                                    st <= S_DESCEND;
                                end
                            end else begin
                                st       <= S_HOLD;
                                hold_cnt <= HOLD_W'(HOLD_CYC);
                            end
                        end
                        S_DESCEND: begin
                            if (s) begin
                                freq <= freq_dn;
                                amp  <= amp_dn;
                                fmin <= (freq_dn != freq);
                                amin <= (amp_dn != amp);
                            end else begin
                                st       <= S_HOLD;
                                hold_cnt <= HOLD_W'(HOLD_CYC);
                            end
                        end
                        S_HOLD: begin
                            if (!s) begin
                                if (hold_cnt <= HOLD_W'(1)) begin
                                    hold_cnt <= '0;
                                    st       <= S_CLIMB;
                                end else begin
                                    hold_cnt <= hold_cnt - HOLD_W'(1);
                                end
                            end else begin
                                st <= flow ? S_CLIMB : S_DESCEND;
                            end
                        end
                        S_FAULT: begin
                            if (clear_err && !s) begin
                                st    <= S_IDLE;
                                error <= 1'b0;
                                freq  <= FREQ_W'(FREQ_INIT);
                                amp   <= AMP_W'(AMP_INIT);
                            end else begin
                                amp  <= amp_dn;
                                amin <= (amp_dn != amp);
                            end
                        end
                        default: st <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_path_search_ctrl.sv
// Directed bench for path_search_ctrl with hand-computed expectations (default parameters).
module tb_path_search_ctrl;

    localparam int ST_IDLE = 0, ST_CLIMB = 1, ST_DESCEND = 2, ST_HOLD = 3, ST_FAULT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] stress_lvl = '0;
    logic       flow = 1'b0;
    logic       clear_err = 1'b0;
    logic [7:0] freq;
    logic [7:0] amp;
    logic       fplus;
    logic       fmin;
    logic       amin;
    logic       error;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_freq;
    int exp_amp;

    always #5 clk = ~clk;

    path_search_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .stress_lvl(stress_lvl),
        .flow      (flow),
        .clear_err (clear_err),
        .freq      (freq),
        .amp       (amp),
        .fplus     (fplus),
        .fmin      (fmin),
        .amin      (amin),
        .error     (error),
        .state     (state)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] sl, input logic fl, input logic clr);
        stress_lvl = sl;
        flow       = fl;
        clear_err  = clr;
        tick       = 1'b1;
        @(posedge clk);
        #1;
        tick      = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic to_climb();
        for (int i = 0; i < 5; i++) step(4'd0, 1'b1, 1'b0);
        chk("to_climb_state", 32'(state), ST_CLIMB);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // 1: reset values, idle cycle, first tick
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_freq", 32'(freq), 128);
        chk("rst_amp", 32'(amp), 200);
        chk("rst_error", 32'(error), 0);
        chk("rst_state", 32'(state), ST_IDLE);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("notick_state", 32'(state), ST_IDLE);
        step(4'd0, 1'b0, 1'b0);
        chk("t1_state", 32'(state), ST_CLIMB);
        chk("t1_fplus", 32'(fplus), 0);
        chk("t1_freq", 32'(freq), 128);

`ifndef STRESS_FILTER_EN
        // 2: climb, hold, periodic re-probe
        exp_freq = 128;
        for (int i = 0; i < 3; i++) begin
            step(4'd9, 1'b1, 1'b0);
            exp_freq += 4;
            chk("climb_freq", 32'(freq), exp_freq);
            chk("climb_fplus", 32'(fplus), 1);
        end
        @(posedge clk);
        #1;
        chk("idle_fplus", 32'(fplus), 0);
        chk("idle_freq", 32'(freq), 140);
        step(4'd2, 1'b1, 1'b0);
        chk("hold_state", 32'(state), ST_HOLD);
        chk("hold_freq", 32'(freq), 140);
        for (int i = 0; i < 3; i++) step(4'd0, 1'b1, 1'b0);
        chk("hold3_state", 32'(state), ST_HOLD);
        step(4'd0, 1'b1, 1'b0);
        chk("probe_state", 32'(state), ST_CLIMB);

        // 3: reversal into DESCEND
        step(4'd12, 1'b0, 1'b0);
        chk("desc_state", 32'(state), ST_DESCEND);
        chk("desc_freq0", 32'(freq), 140);
        step(4'd12, 1'b0, 1'b0);
        chk("desc_freq", 32'(freq), 136);
        chk("desc_amp", 32'(amp), 196);
        chk("desc_fmin", 32'(fmin), 1);
        chk("desc_amin", 32'(amin), 1);

        // 4: climb to the upper bound, interleaving holds to keep the bad counter low
        to_climb();
        exp_freq = 136;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 14; i++) begin
                step(4'd9, 1'b1, 1'b0);
                exp_freq += 4;
            end
            chk("run_freq", 32'(freq), exp_freq);
            to_climb();
        end
        step(4'd9, 1'b1, 1'b0);
        chk("near_freq", 32'(freq), 252);
        step(4'd9, 1'b1, 1'b0);
        chk("sat_freq", 32'(freq), 255);
        chk("sat_fplus", 32'(fplus), 1);
        step(4'd9, 1'b1, 1'b0);
        chk("sat_hold_freq", 32'(freq), 255);
        chk("sat_no_fplus", 32'(fplus), 0);

        // 5: persistent stress -> FAULT, amp drain, clear handling
        reset = 1'b0;
        step(4'd0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) step(4'd15, 1'b1, 1'b0);
        chk("pre_fault_state", 32'(state), ST_CLIMB);
        chk("pre_fault_freq", 32'(freq), 184);
        chk("pre_fault_error", 32'(error), 0);
        step(4'd15, 1'b1, 1'b1);
        chk("fault_state", 32'(state), ST_FAULT);
        chk("fault_error", 32'(error), 1);
        chk("fault_freq", 32'(freq), 184);
        chk("fault_amp", 32'(amp), 200);
        exp_amp = 200;
        for (int i = 0; i < 50; i++) begin
            step(4'd15, 1'b1, (i == 3) ? 1'b1 : 1'b0);
            exp_amp -= 4;
            chk("drain_amp", 32'(amp), exp_amp);
            chk("drain_amin", 32'(amin), 1);
            chk("drain_state", 32'(state), ST_FAULT);
        end
        chk("drain_freq", 32'(freq), 184);
        step(4'd15, 1'b1, 1'b0);
        chk("amp_floor", 32'(amp), 0);
        chk("amp_floor_amin", 32'(amin), 0);
        step(4'd0, 1'b0, 1'b1);
        chk("clr_state", 32'(state), ST_IDLE);
        chk("clr_error", 32'(error), 0);
        chk("clr_freq", 32'(freq), 128);
        chk("clr_amp", 32'(amp), 200);
`endif

        // 6: reset mid-DESCEND with tick high
        reset = 1'b0;
        step(4'd0, 1'b0, 1'b0);
        reset = 1'b1;
        step(4'd12, 1'b0, 1'b0);
        step(4'd12, 1'b0, 1'b0);
        chk("r6_state", 32'(state), ST_DESCEND);
        step(4'd12, 1'b0, 1'b0);
        chk("r6_freq", 32'(freq), 124);
        chk("r6_amp", 32'(amp), 196);
        reset = 1'b0;
        step(4'd12, 1'b0, 1'b0);
        chk("mid_rst_state", 32'(state), ST_IDLE);
        chk("mid_rst_freq", 32'(freq), 128);
        chk("mid_rst_amp", 32'(amp), 200);
        chk("mid_rst_fmin", 32'(fmin), 0);
        chk("mid_rst_amin", 32'(amin), 0);
        chk("mid_rst_error", 32'(error), 0);
        reset = 1'b1;

        // Single stressed tick while in HOLD
        step(4'd0, 1'b1, 1'b0);
        step(4'd0, 1'b1, 1'b0);
        chk("glitch_pre_state", 32'(state), ST_HOLD);
        step(4'd9, 1'b1, 1'b0);
`ifdef STRESS_FILTER_EN
        chk("glitch_state", 32'(state), ST_HOLD);
`else
        chk("glitch_state", 32'(state), ST_CLIMB);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
